// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : EX-stage controller for a multi-cycle HI/LO divider.
//               Detects DIV/DIVU, captures the operands, holds a level start
//               request to the divider until it reports ready, and then writes
//               the 64-bit result to HI/LO with a single-cycle strobe. A
//               pipeline flush or a watchdog expiry cancels the request. After
//               a cancel, the controller waits in a fixed 2-cycle ABORT window
//               so that the divider is idle before the next start.
//
// Ports       : clk            system clock, rising edge
//               rst            synchronous active-high reset
//               aluop_i        EX-stage opcode (DIV / DIVU detected)
//               reg1_i/reg2_i  dividend / divisor from EX
//               flush_i        pipeline flush, kills in-flight divide
//               div_result_i   {remainder, quotient} from divider
//               div_ready_i    divider result valid
//               div_opdata1_o  captured dividend to divider
//               div_opdata2_o  captured divisor to divider
//               signed_div_o   1 = signed divide
//               div_start_o    level divide request
//               div_annul_o    cancel request to divider
//               stallreq_o     stall request to pipeline control
//               hilo_we_o      one-cycle HI/LO write strobe
//               hi_o / lo_o    remainder / quotient for HI/LO
//               timeout_o      sticky watchdog error flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        signed_div_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    localparam logic [7:0] C_OP_DIV   = 8'b00011010;
    localparam logic [7:0] C_OP_DIVU  = 8'b00011011;
    // Watchdog value seen in the 48th WAIT cycle (counter starts at 0).
    localparam logic [5:0] C_WD_LAST  = 6'd47;
    // ABORT counter value seen in the second (last) ABORT cycle.
    localparam logic [1:0] C_ABT_LAST = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic        r_signed;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_wd_cnt;
    logic [1:0]  r_abt_cnt;
    logic        r_timeout;

    logic        w_is_div;
    logic        w_req;
    logic        w_wd_expired;

    logic        w_start;
    logic        w_annul;
    logic        w_stall;
    logic        w_we;

    assign w_is_div     = (aluop_i == C_OP_DIV) || (aluop_i == C_OP_DIVU);
    // A divide only counts as a new request when it is not being flushed.
    assign w_req        = w_is_div && !flush_i;
    assign w_wd_expired = (r_wd_cnt == C_WD_LAST);

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_signed  <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_wd_cnt  <= 6'd0;
            r_abt_cnt <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;

            // The ABORT window always begins counting from zero.
            if (r_state == S_ABORT) begin
                r_abt_cnt <= r_abt_cnt + 2'd1;
            end else begin
                r_abt_cnt <= 2'd0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_op1    <= reg1_i;
                        r_op2    <= reg2_i;
                        r_signed <= (aluop_i == C_OP_DIV);
                        r_wd_cnt <= 6'd0;
                    end
                end
                S_WAIT: begin
                    // Flush outranks a simultaneous ready: the result is dropped.
                    if (!flush_i) begin
                        if (div_ready_i) begin
                            r_hi <= div_result_i[63:32];
                            r_lo <= div_result_i[31:0];
                        end else if (w_wd_expired) begin
                            r_timeout <= 1'b1;
                        end else begin
                            r_wd_cnt <= r_wd_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_annul = 1'b0;
        w_stall = 1'b0;
        w_we    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next  = S_WAIT;
                    w_stall = 1'b1;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (flush_i) begin
                    w_annul = 1'b1;
                    w_next  = S_ABORT;
                end else begin
                    w_start = 1'b1;
                    if (div_ready_i) begin
                        w_next = S_DONE;
                    end else if (w_wd_expired) begin
                        w_next = S_ABORT;
                    end
                end
            end
            S_DONE: begin
                // A new opcode here is ignored; it is picked up from IDLE.
                w_we   = !flush_i;
                w_next = S_IDLE;
            end
            S_ABORT: begin
                w_annul = 1'b1;
                // Hold a waiting divide in EX until the divider is free.
                w_stall = w_req;
                if (r_abt_cnt == C_ABT_LAST) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Request lines stay quiet while reset is asserted, whatever the
        // state register held before the reset edge.
        if (rst) begin
            w_start = 1'b0;
            w_annul = 1'b0;
            w_stall = 1'b0;
            w_we    = 1'b0;
        end
    end

    assign div_opdata1_o = r_op1;
    assign div_opdata2_o = r_op2;
    assign signed_div_o  = r_signed;
    assign div_start_o   = w_start;
    assign div_annul_o   = w_annul;
    assign stallreq_o    = w_stall;
    assign hilo_we_o     = w_we;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign timeout_o     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl. Contains a behavioural
//               divider with programmable latency (0 = never ready) and a
//               queue of expected HI/LO values that is drained on every
//               hilo_we_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    localparam logic [7:0] C_DIV  = 8'b00011010;
    localparam logic [7:0] C_DIVU = 8'b00011011;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic        signed_div_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        timeout_o;

    div_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .aluop_i       (aluop_i),
        .reg1_i        (reg1_i),
        .reg2_i        (reg2_i),
        .flush_i       (flush_i),
        .div_result_i  (div_result_i),
        .div_ready_i   (div_ready_i),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .signed_div_o  (signed_div_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .stallreq_o    (stallreq_o),
        .hilo_we_o     (hilo_we_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .timeout_o     (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural divider: ready in the lat_cfg-th cycle of a request,
    // held while the request (or its annul) is visible.
    // ------------------------------------------------------------------
    int          lat_cfg;
    logic [5:0]  m_cnt;

    always @(posedge clk) begin
        if (rst || !div_start_o) m_cnt <= 6'd0;
        else if (m_cnt != 6'd63) m_cnt <= m_cnt + 6'd1;
    end

    assign div_ready_i = (div_start_o || div_annul_o) && (lat_cfg > 0)
                         && (int'(m_cnt) >= lat_cfg - 1);

    always_comb begin
        div_result_i = 64'd0;
        if (div_opdata2_o == 32'd0) begin
            div_result_i = {div_opdata1_o, 32'hFFFF_FFFF};
        end else if (signed_div_o) begin
            div_result_i = {32'($signed(div_opdata1_o) % $signed(div_opdata2_o)),
                            32'($signed(div_opdata1_o) / $signed(div_opdata2_o))};
        end else begin
            div_result_i = {div_opdata1_o % div_opdata2_o,
                            div_opdata1_o / div_opdata2_o};
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_writes = 0;
    logic [63:0] sb[$];
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic        cur_s;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every HI/LO write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (hilo_we_o) begin
            n_writes++;
            if (sb.size() == 0) begin
                check_eq("unexpected_hilo_write", 64'd1, 64'd0);
            end else begin
                check_eq("hilo_value", {hi_o, lo_o}, sb.pop_front());
            end
        end
    end

    // Present an opcode for one IDLE cycle; returns #1 after the WAIT entry edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat);
        @(posedge clk);
        #1;
        aluop_i = op;
        reg1_i  = a;
        reg2_i  = b;
        lat_cfg = lat;
        cur_a   = a;
        cur_b   = b;
        cur_s   = (op == C_DIV);
        @(negedge clk);
        check_eq("idle_stall", 64'(stallreq_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Follow the WAIT phase; ends at the negedge of the first cycle after WAIT.
    task automatic finish_div(input int exp_cycles, input bit exp_write, input bit toggle);
        int n   = 0;
        int bad = 0;
        @(negedge clk);
        while (div_start_o && n < 200) begin
            n++;
            if ({div_opdata1_o, div_opdata2_o, signed_div_o} !== {cur_a, cur_b, cur_s}
                || stallreq_o !== 1'b1 || div_annul_o !== 1'b0 || hilo_we_o !== 1'b0)
                bad++;
            if (toggle) begin
                reg1_i = $urandom;
                reg2_i = $urandom;
            end
            @(negedge clk);
        end
        check_eq("wait_cycles", 64'(n), 64'(exp_cycles));
        check_eq("wait_outputs_bad", 64'(bad), 64'd0);
        check_eq("post_wait_we", 64'(hilo_we_o), 64'(exp_write));
        if (exp_write) check_eq("done_stall", 64'(stallreq_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        aluop_i = 8'd0;
        reg1_i  = 32'd0;
        reg2_i  = 32'd0;
        flush_i = 1'b0;
        lat_cfg = 0;
        cur_a   = 32'd0;
        cur_b   = 32'd0;
        cur_s   = 1'b0;

        // Reset: a DIV opcode during reset must not raise stall.
        repeat (2) @(posedge clk);
        #1 aluop_i = C_DIV;
        @(negedge clk);
        check_eq("reset_ctrl", 64'({div_start_o, div_annul_o, hilo_we_o, stallreq_o, timeout_o}), 64'd0);
        check_eq("reset_hilo", {hi_o, lo_o}, 64'd0);
        @(posedge clk);
        #1;
        aluop_i = 8'd0;
        rst     = 1'b0;

        // Signed -7 / 2 with a 34-cycle divider.
        sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(C_DIV, 32'hFFFF_FFF9, 32'd2, 34);
        aluop_i = 8'd0;
        finish_div(34, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("we_single_pulse", 64'(hilo_we_o), 64'd0);
        check_eq("hilo_hold", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Unsigned 100 / 7, opcode held and operands toggling during WAIT.
        sb.push_back({32'd2, 32'd14});
        issue(C_DIVU, 32'd100, 32'd7, 20);
        finish_div(20, 1'b1, 1'b1);
        @(posedge clk);
        #1 aluop_i = 8'd0;
        @(negedge clk);
        check_eq("done_no_restart", 64'({div_start_o, hilo_we_o, stallreq_o}), 64'd0);

        // Flush in WAIT cycle 10, then a back-to-back divide.
        issue(C_DIV, 32'd50, 32'd7, 34);
        aluop_i = 8'd0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_annul_start", 64'({div_annul_o, div_start_o, hilo_we_o}), 64'b100);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        aluop_i = C_DIV;
        reg1_i  = 32'd20;
        reg2_i  = 32'd3;
        cur_a   = 32'd20;
        cur_b   = 32'd3;
        cur_s   = 1'b1;
        lat_cfg = 8;
        sb.push_back({32'd2, 32'd6});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("abort_outputs", 64'({div_annul_o, div_start_o, stallreq_o, hilo_we_o}), 64'b1010);
        end
        @(negedge clk);
        check_eq("after_abort_idle", 64'({div_annul_o, div_start_o, stallreq_o}), 64'b001);
        @(posedge clk);
        #1 aluop_i = 8'd0;
        finish_div(8, 1'b1, 1'b0);

        // Flush coincident with ready.
        issue(C_DIV, 32'd7, 32'hFFFF_FFFE, 5);
        aluop_i = 8'd0;
        repeat (4) @(posedge clk);
        #1 flush_i = 1'b1;
        @(negedge clk);
        check_eq("flush_ready_outputs", 64'({div_annul_o, div_start_o, hilo_we_o}), 64'b100);
        @(posedge clk);
        #1 flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("flush_ready_abort", 64'({div_annul_o, hilo_we_o}), 64'b10);
        end
        @(negedge clk);
        check_eq("flush_ready_idle", 64'(div_annul_o), 64'd0);

        // Signed 7 / -2 and unsigned divide-by-zero.
        sb.push_back({32'd1, 32'hFFFF_FFFD});
        issue(C_DIV, 32'd7, 32'hFFFF_FFFE, 3);
        aluop_i = 8'd0;
        finish_div(3, 1'b1, 1'b0);
        sb.push_back({32'd5, 32'hFFFF_FFFF});
        issue(C_DIVU, 32'd5, 32'd0, 3);
        aluop_i = 8'd0;
        finish_div(3, 1'b1, 1'b0);

        // Watchdog: divider never answers.
        issue(C_DIV, 32'd1, 32'd1, 0);
        aluop_i = 8'd0;
        finish_div(48, 1'b0, 1'b0);
        check_eq("timeout_set", 64'({timeout_o, div_annul_o}), 64'b11);
        repeat (5) @(negedge clk);
        check_eq("timeout_sticky", 64'(timeout_o), 64'd1);

        // Reset in the middle of WAIT.
        issue(C_DIVU, 32'd9, 32'd2, 34);
        aluop_i = 8'd0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_wait_during", 64'({div_start_o, div_annul_o, stallreq_o, hilo_we_o}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_ctrl", 64'({div_start_o, div_annul_o, hilo_we_o, stallreq_o, timeout_o, signed_div_o}), 64'd0);
        check_eq("rst_wait_hilo", {hi_o, lo_o}, 64'd0);
        check_eq("rst_wait_opdata", {div_opdata1_o, div_opdata2_o}, 64'd0);
        @(negedge clk);
        check_eq("rst_wait_idle", 64'(div_start_o), 64'd0);

        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
        check_eq("write_count", 64'(n_writes), 64'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high (1 = reset).
REQ-003 aluop_i  in  8  EX-stage opcode; 8'b00011010 = DIV (signed), 8'b00011011 = DIVU; any other value = no divide.
REQ-004 reg1_i, reg2_i  in  32 each  dividend, divisor from EX stage.
REQ-005 flush_i  in  1  pipeline flush; kills the in-flight divide.
REQ-006 div_result_i  in  64  divider result {remainder[63:32], quotient[31:0]}.
REQ-007 div_ready_i  in  1  divider result valid; held high until div_start_o drops.
REQ-008 div_opdata1_o, div_opdata2_o  out  32 each  operands to divider.
REQ-009 signed_div_o  out  1  1 = signed divide.
REQ-010 div_start_o  out  1  divide request, level.
REQ-011 div_annul_o  out  1  cancel request to divider.
REQ-012 stallreq_o  out  1  stall request to pipeline control.
REQ-013 hilo_we_o  out  1  one-cycle HI/LO write strobe.
REQ-014 hi_o, lo_o  out  32 each  remainder, quotient for HI/LO.
REQ-015 timeout_o  out  1  sticky watchdog error flag.

Function
REQ-016 FSM states: IDLE, WAIT, DONE, ABORT; registered state, encoded as 2 bits.
REQ-017 IDLE: aluop_i = DIV/DIVU and flush_i=0 -> capture reg1_i, reg2_i, signedness into registers; enter WAIT next edge; stallreq_o=1 combinationally in this same cycle.
REQ-018 WAIT: div_start_o=1; div_opdata*_o and signed_div_o driven from captured registers (stable for whole request); stallreq_o=1.
REQ-019 WAIT and div_ready_i=1 -> latch div_result_i into hi/lo registers; enter DONE.
REQ-020 DONE: div_start_o=0, stallreq_o=0, hilo_we_o=1 for exactly one cycle, hi_o=result[63:32], lo_o=result[31:0]; always enter IDLE next edge; opcode present in DONE never starts a new request.
REQ-021 hilo_we_o=0 in every state except DONE; hi_o/lo_o hold last latched value otherwise.
REQ-022 Flush: flush_i=1 in WAIT -> div_annul_o=1, div_start_o=0 that cycle; enter ABORT; no HI/LO write.
REQ-023 Flush priority: flush_i=1 in WAIT with div_ready_i=1 simultaneously -> flush wins, result discarded.
REQ-024 flush_i=1 in DONE -> hilo_we_o forced 0, go IDLE.
REQ-025 ABORT: div_start_o=0, div_annul_o=1; lasts exactly 2 cycles (2-bit counter), then IDLE; guarantees divider has returned to free before next start.
REQ-026 ABORT: stallreq_o=1 if aluop_i is DIV/DIVU and flush_i=0 (new divide waits), else 0.
REQ-027 Watchdog: 6-bit counter, cleared on WAIT entry, increments each WAIT cycle; reaching 48 without div_ready_i -> timeout_o=1 (sticky), enter ABORT, no HI/LO write.
REQ-028 Divide-by-zero not special-cased: divider result written to HI/LO as returned.
REQ-029 div_annul_o=0 in IDLE, WAIT (no flush), DONE.
REQ-030 All outputs derived from registered state plus REQ-017/REQ-022/REQ-026 combinational terms only; no combinational path from div_result_i to outputs.

Reset
REQ-031 rst=1 at edge -> state IDLE, counters 0, captured operands 0, hi/lo registers 0, timeout_o=0.
REQ-032 During and after reset edge: div_start_o=0, div_annul_o=0, hilo_we_o=0, stallreq_o=0, hi_o=lo_o=0.
REQ-033 Reset mid-WAIT abandons request without ABORT sequencing; divider is reset by same rst.

Verification
REQ-034 DIV reg1=0xFFFFFFF9 (-7), reg2=2, divider model returns ready after 34 cycles with {0xFFFFFFFF,0xFFFFFFFD} -> start high 34 cycles, stallreq high through WAIT, one hilo_we pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFD.
REQ-035 DIVU reg1=100, reg2=7 -> signed_div_o=0, hi=2, lo=14, exactly one write; operands unchanged though reg1_i/reg2_i toggle during WAIT.
REQ-036 flush_i at WAIT cycle 10 -> annul=1, start=0, 2-cycle ABORT, no hilo_we; back-to-back DIV after flush starts only after ABORT ends.
REQ-037 flush_i coincident with div_ready_i -> no hilo_we, enter ABORT.
REQ-038 divider model never asserts ready -> at WAIT cycle 48 timeout_o=1, ABORT, stays 1 until rst.
REQ-039 rst asserted mid-WAIT -> next cycle all outputs at reset values, state IDLE.
